max_unpool: RTL and testbench

MAX_UNPOOL -- requirements
Module: max_unpool

---
 rtl/conv_net_pkg.sv | 7 +
 rtl/unpool_line_buffer.sv | 23 ++
 rtl/max_unpool.sv | 139 +++++++++++++
 tb/tb_max_unpool.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_net_pkg.sv
// conv_net_pkg: shared types and helpers for the conv-net streaming blocks.
package conv_net_pkg;
   typedef enum logic {FILL, REPLAY} unpool_state_e;
   function automatic int cnt_w(input int range);
      return (range > 1) ? $clog2(range) : 1;
   endfunction
endpackage

// File: rtl/unpool_line_buffer.sv
// unpool_line_buffer: one pooled row of pixels, single write port, registered read port, no reset.
module unpool_line_buffer
   import conv_net_pkg::*;
#(
   parameter int bitwidth = 8,
   parameter int depth = 12,
   localparam int AW = cnt_w(depth)
) (
   input  logic                clk,
   input  logic                wr_en_i,
   input  logic [AW-1:0]       wr_addr_i,
   input  logic [bitwidth-1:0] wr_data_i,
   input  logic [AW-1:0]       rd_addr_i,
   output logic [bitwidth-1:0] rd_data_o
);
   logic [bitwidth-1:0] mem_q [depth];
   logic [bitwidth-1:0] rd_data_q;
   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_data_q <= mem_q[rd_addr_i];
   end
   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/max_unpool.sv
// max_unpool: streams pooled pixels out as scale x scale nearest-neighbour blocks.
// Defining MAX_UNPOOL_ZERO_FILL_EN places each pixel only at block (0,0) and zeros elsewhere.
module max_unpool
   import conv_net_pkg::*;
#(
   parameter int bitwidth = 8,
   parameter int datawidth = 24,
   parameter int dataheight = 24,
   parameter int datachannel = 2,
   parameter int scale = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [bitwidth-1:0] in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [bitwidth-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_last
);
   localparam int PW = datawidth / scale;
   localparam int PH = dataheight / scale;
   localparam int CW = cnt_w(PW);
   localparam int RW = cnt_w(scale);
   localparam int YW = cnt_w(PH);
   localparam int HW = cnt_w(datachannel);
   localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
   localparam logic [RW-1:0] REP_LAST = RW'(scale - 1);
   localparam logic [YW-1:0] ROW_LAST = YW'(PH - 1);
   localparam logic [HW-1:0] CH_LAST = HW'(datachannel - 1);
`ifdef MAX_UNPOOL_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif

   unpool_state_e       state_q, state_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       rep_q, rep_d, vrow_q, vrow_d;
   logic [YW-1:0]       row_q, row_d;
   logic [HW-1:0]       ch_q, ch_d;
   logic [bitwidth-1:0] data_q, data_d;
   logic                valid_q, valid_d, last_q, last_d;
   logic                out_fire, in_fire, rep_last, col_last, wr_en;
   logic [CW-1:0]       rd_addr;
   logic [bitwidth-1:0] rd_data, hold_pix, next_pix;

   unpool_line_buffer #(.bitwidth(bitwidth), .depth(PW)) u_lb (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_addr_i (col_d),
      .wr_data_i (in_data),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   // col_q is the column held in the output register, or the next column expected when it is empty
   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      rep_d    = rep_q;
      vrow_d   = vrow_q;
      row_d    = row_q;
      ch_d     = ch_q;
      data_d   = data_q;
      valid_d  = valid_q;
      wr_en    = 1'b0;
      out_fire = valid_q && out_ready;
      rep_last = rep_q == REP_LAST;
      col_last = col_q == COL_LAST;
      in_ready = state_q == FILL && (!valid_q || (out_fire && rep_last && !col_last));
      in_fire  = in_valid && in_ready;
      hold_pix = ZF ? '0 : data_q;
      next_pix = ZF ? '0 : rd_data;
      if (in_fire) begin
         data_d  = in_data;
         valid_d = 1'b1;
         rep_d   = '0;
         col_d   = valid_q ? col_q + 1'b1 : col_q;
         wr_en   = 1'b1;
      end else if (out_fire && !rep_last) begin
         rep_d  = rep_q + 1'b1;
         data_d = hold_pix;
      end else if (out_fire && !col_last) begin
         rep_d   = '0;
         col_d   = col_q + 1'b1;
         valid_d = state_q == REPLAY;
         data_d  = state_q == REPLAY ? next_pix : data_q;
      end else if (out_fire && (state_q == FILL || vrow_q != REP_LAST)) begin
         state_d = REPLAY;
         vrow_d  = vrow_q + 1'b1;
         col_d   = '0;
         rep_d   = '0;
         data_d  = next_pix;
      end else if (out_fire) begin
         state_d = FILL;
         vrow_d  = '0;
         col_d   = '0;
         rep_d   = '0;
         valid_d = 1'b0;
         row_d   = row_q == ROW_LAST ? '0 : row_q + 1'b1;
         ch_d    = row_q != ROW_LAST ? ch_q : (ch_q == CH_LAST ? '0 : ch_q + 1'b1);
      end
      last_d = valid_d && state_d == REPLAY && row_q == ROW_LAST && ch_q == CH_LAST &&
               vrow_d == REP_LAST && col_d == COL_LAST && rep_d == REP_LAST;
   end

   // prefetch the column replayed next so the registered read is ready by its load edge
   assign rd_addr = (state_q == REPLAY && !col_last) ? col_q + 1'b1 : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         col_q   <= '0;
         rep_q   <= '0;
         vrow_q  <= '0;
         row_q   <= '0;
         ch_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         rep_q   <= rep_d;
         vrow_q  <= vrow_d;
         row_q   <= row_d;
         ch_q    <= ch_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
endmodule

// File: tb/tb_max_unpool.sv
// tb_max_unpool: randomized self-checking bench for max_unpool over three geometries.
module tb_max_unpool;
   typedef int iq_t[$];
`ifdef MAX_UNPOOL_ZERO_FILL_EN
   localparam bit ZF = 1'b1;
`else
   localparam bit ZF = 1'b0;
`endif
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data [3];
   logic [7:0] out_data [3];
   logic       in_valid [3];
   logic       in_ready [3];
   logic       out_valid [3];
   logic       out_ready [3];
   logic       out_last [3];
   int         checks = 0;
   int         passed = 0;

   always #5 clk = ~clk;

   max_unpool #(.bitwidth(8), .datawidth(4), .dataheight(4), .datachannel(1), .scale(2)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_last(out_last[0]));
   max_unpool #(.bitwidth(8), .datawidth(4), .dataheight(4), .datachannel(2), .scale(2)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_last(out_last[1]));
   max_unpool #(.bitwidth(8), .datawidth(6), .dataheight(6), .datachannel(1), .scale(3)) dut2 (
      .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_last(out_last[2]));

   function automatic int gw(input int k); return k == 2 ? 6 : 4; endfunction
   function automatic int gc(input int k); return k == 1 ? 2 : 1; endfunction
   function automatic int gs(input int k); return k == 2 ? 3 : 2; endfunction

   function automatic iq_t rnd(input int n);
      iq_t q;
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(255)));
      return q;
   endfunction

   // reference: every output pixel (c,y,x) comes from pooled pixel (c,y/s,x/s)
   task automatic run(input int k, input iq_t din, input int pr, input int pv, input int stop_after);
      int  ed[$];
      bit  el[$];
      bit  er[$];
      int  s = gs(k);
      int  w = gw(k);
      int  c = gc(k);
      int  pw = w / s;
      int  fsz = pw * pw * c;
      int  ii = 0;
      int  beats = 0;
      int  cyc = 0;
      int  budget;
      bit  stalled = 1'b0;
      logic [7:0] hd = '0;
      logic hl = 1'b0;
      for (int f = 0; f < din.size() / fsz; f++)
         for (int ch = 0; ch < c; ch++)
            for (int y = 0; y < w; y++)
               for (int x = 0; x < w; x++) begin
                  int v = din[f * fsz + ch * pw * pw + (y / s) * pw + x / s];
                  ed.push_back((ZF && (y % s != 0 || x % s != 0)) ? 0 : v);
                  el.push_back(ch == c - 1 && y == w - 1 && x == w - 1);
                  er.push_back(y % s != 0);
               end
      budget = 20 * ed.size() + 100;
      while (ed.size() > 0 && beats != stop_after) begin
         @(negedge clk);
         if (cyc++ > budget) begin
            checks++;
            $display("FAIL timeout k=%0d beats got %0d required %0d more", k, beats, ed.size());
            break;
         end
         out_ready[k] = $urandom_range(99) < pr;
         in_valid[k]  = ii < din.size() && $urandom_range(99) < pv;
         in_data[k]   = ii < din.size() ? 8'(din[ii]) : 8'($urandom);
         #1;
         if (stalled) begin
            checks++;
            if (out_valid[k] !== 1'b1 || out_data[k] !== hd || out_last[k] !== hl)
               $display("FAIL stall_hold k=%0d got v=%b d=%0d l=%b required v=1 d=%0d l=%b",
                        k, out_valid[k], out_data[k], out_last[k], hd, hl);
            else passed++;
         end
         if (out_valid[k] === 1'b1 && er[0]) begin
            checks++;
            if (in_ready[k] !== 1'b0) $display("FAIL replay_in_ready k=%0d got %b required 0", k, in_ready[k]);
            else passed++;
         end
         stalled = out_valid[k] === 1'b1 && !out_ready[k];
         hd = out_data[k];
         hl = out_last[k];
         if (out_valid[k] === 1'b1 && out_ready[k]) begin
            checks++;
            if ({out_last[k], out_data[k]} !== {el[0], 8'(ed[0])})
               $display("FAIL beat k=%0d n=%0d got d=%0d l=%b required d=%0d l=%b",
                        k, beats, out_data[k], out_last[k], ed[0], el[0]);
            else passed++;
            void'(ed.pop_front());
            void'(el.pop_front());
            void'(er.pop_front());
            beats++;
         end
         if (in_valid[k] && in_ready[k] === 1'b1) ii++;
      end
      if (stop_after < 0) begin
         @(negedge clk);
         out_ready[k] = 1'b1;
         in_valid[k]  = 1'b0;
         #1;
         checks++;
         if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1)
            $display("FAIL frame_end k=%0d got v=%b r=%b required v=0 r=1", k, out_valid[k], in_ready[k]);
         else passed++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({out_valid[k], out_last[k], out_data[k]} !== 10'd0)
            $display("FAIL reset_out k=%0d got v=%b l=%b d=%0d required 0", k, out_valid[k], out_last[k], out_data[k]);
         else passed++;
      end
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (in_ready[k] !== 1'b1) $display("FAIL reset_in_ready k=%0d got %b required 1", k, in_ready[k]);
         else passed++;
      end
   endtask

   task automatic test_basic();
      int rep[16] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
      int zf[16]  = '{1, 0, 2, 0, 0, 0, 0, 0, 3, 0, 4, 0, 0, 0, 0, 0};
      int ii = 0, n = 0, cyc = 0, fi = -1, fo = -1;
      while (n < 16 && cyc < 200) begin
         @(negedge clk);
         out_ready[0] = 1'b1;
         in_valid[0]  = ii < 4;
         in_data[0]   = 8'(ii + 1);
         #1;
         if (out_valid[0] === 1'b1) begin
            if (fo < 0) fo = cyc;
            checks++;
            if (out_data[0] !== 8'(ZF ? zf[n] : rep[n]) || out_last[0] !== (n == 15))
               $display("FAIL basic n=%0d got d=%0d l=%b required d=%0d l=%b",
                        n, out_data[0], out_last[0], ZF ? zf[n] : rep[n], n == 15);
            else passed++;
            n++;
         end
         if (in_valid[0] && in_ready[0] === 1'b1) begin
            if (fi < 0) fi = cyc;
            ii++;
         end
         cyc++;
      end
      in_valid[0] = 1'b0;
      checks++;
      if (n != 16) $display("FAIL basic_count got %0d required 16", n);
      else passed++;
      checks++;
      if (fo != fi + 1) $display("FAIL latency got %0d required 1", fo - fi);
      else passed++;
   endtask

   task automatic test_stall();
      run(0, '{1, 2, 3, 4}, 50, 70, -1);
      run(0, rnd(8), 40, 60, -1);
   endtask

   task automatic test_channels();
      run(1, '{1, 2, 3, 4, 5, 6, 7, 8}, 100, 100, -1);
      run(1, rnd(16), 60, 60, -1);
   endtask

   task automatic test_reset_mid();
      run(0, '{1, 2, 3, 4}, 100, 100, 5);
      @(posedge clk);
      #2;
      in_valid[0] = 1'b0;
      rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({out_valid[0], out_last[0], out_data[0]} !== 10'd0)
            $display("FAIL reset_mid i=%0d got v=%b l=%b d=%0d required 0", i, out_valid[0], out_last[0], out_data[0]);
         else passed++;
         @(negedge clk);
      end
      rst = 1'b0;
      run(0, '{9, 8, 7, 6}, 100, 100, -1);
   endtask

   task automatic test_scale3();
      run(2, '{1, 2, 3, 4}, 100, 100, -1);
      run(2, rnd(4), 50, 50, -1);
   endtask

   task automatic test_back_to_back();
      run(0, rnd(12), 100, 100, -1);
      run(1, rnd(24), 100, 100, -1);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         in_data[k]   = '0;
         in_valid[k]  = 1'b0;
         out_ready[k] = 1'b0;
      end
      test_reset();
      test_basic();
      test_stall();
      test_channels();
      test_reset_mid();
      test_scale3();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
